// File: rtl/servo_angle_sequencer_if.sv
// Target-angle write port: valid/ready handshake carrying a channel select and angle.
interface servo_angle_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_ch;
  logic [7:0] cmd_angle;

  modport master (output cmd_valid, output cmd_ch, output cmd_angle, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ch, input cmd_angle, output cmd_ready);
endinterface

// File: rtl/servo_angle_sequencer.sv
// Four-channel servo angle slewer: moves each output toward its target by at most
// STEP degrees once per update period and strobes nextangle after any change.
module servo_angle_sequencer #(
  parameter int UPDATE_CYCLES = 1_000_000,
  parameter int STEP          = 2,
  parameter int MAX_ANGLE     = 180,
  parameter int RESET_ANGLE   = 90
) (
  input  logic                   clk,
  input  logic                   rst,
  servo_angle_sequencer_if.slave cmd,
  output logic [7:0]             angle1,
  output logic [7:0]             angle2,
  output logic [7:0]             angle3,
  output logic [7:0]             angle4,
  output logic                   nextangle,
  output logic                   busy
);
  typedef enum logic [1:0] {S_INIT, S_WAIT, S_STROBE} state_t;

  localparam int              CW    = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST  = CW'(UPDATE_CYCLES - 1);
  localparam logic [8:0]      STEP9 = 9'(STEP);
  localparam logic [7:0]      MAXA  = 8'(MAX_ANGLE);
  localparam logic [7:0]      RSTA  = 8'(RESET_ANGLE);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    cur    [4];
  logic [7:0]    tgt    [4];
  logic [7:0]    cur_nx [4];
  logic [7:0]    tgt_nx [4];
  logic [7:0]    wdata;
  logic          tick;
  logic          accept;
  logic          changed;
  logic          busy_nx;

  // One bounded step toward the target; the step shrinks to land exactly on it.
  function automatic logic [7:0] slew(input logic [7:0] c, input logic [7:0] t);
    logic [8:0] d;
    d = '0;
    if (c < t) begin
      d    = {1'b0, t} - {1'b0, c};
      slew = 8'({1'b0, c} + ((d < STEP9) ? d : STEP9));
    end else if (c > t) begin
      d    = {1'b0, c} - {1'b0, t};
      slew = 8'({1'b0, c} - ((d < STEP9) ? d : STEP9));
    end else begin
      slew = c;
    end
  endfunction

  assign tick   = (state == S_WAIT) && (cnt == LAST);
  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign wdata  = (cmd.cmd_angle > MAXA) ? MAXA : cmd.cmd_angle;

  // A write landing on a tick edge only affects tgt_nx, so the tick slews toward the old target.
  always_comb begin
    changed = 1'b0;
    busy_nx = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cur_nx[i] = tick ? slew(cur[i], tgt[i]) : cur[i];
      tgt_nx[i] = tgt[i];
      if (accept && (cmd.cmd_ch == 2'(i))) tgt_nx[i] = wdata;
      if (cur_nx[i] != cur[i]) changed = 1'b1;
      if (cur_nx[i] != tgt_nx[i]) busy_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_INIT;
      cnt           <= '0;
      nextangle     <= 1'b0;
      busy          <= 1'b0;
      cmd.cmd_ready <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        cur[i] <= RSTA;
        tgt[i] <= RSTA;
      end
    end else begin
      nextangle <= 1'b0;
      busy      <= busy_nx;
      for (int unsigned i = 0; i < 4; i++) begin
        cur[i] <= cur_nx[i];
        tgt[i] <= tgt_nx[i];
      end
      if (state != S_INIT) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      case (state)
        S_INIT: begin
          nextangle     <= 1'b1;
          cmd.cmd_ready <= 1'b1;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (tick && changed) state <= S_STROBE;
        end
        S_STROBE: begin
          nextangle <= 1'b1;
          state     <= S_WAIT;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign angle1 = cur[0];
  assign angle2 = cur[1];
  assign angle3 = cur[2];
  assign angle4 = cur[3];
endmodule

// File: tb/tb_servo_angle_sequencer.sv
// Self-checking bench for servo_angle_sequencer against a cycle-level behavioural model.
module tb_servo_angle_sequencer;
  localparam int UC   = 8;
  localparam int ST   = 2;
  localparam int MAXA = 180;
  localparam int RSTA = 90;
  localparam logic [34:0] RST_VEC  = {8'd90, 8'd90, 8'd90, 8'd90, 3'b000};
  localparam logic [34:0] INIT_VEC = {8'd90, 8'd90, 8'd90, 8'd90, 3'b101};
  localparam logic [34:0] IDLE_VEC = {8'd90, 8'd90, 8'd90, 8'd90, 3'b001};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic       nextangle, busy;
  int         checks = 0;
  int         errors = 0;

  servo_angle_sequencer_if cif();

  servo_angle_sequencer #(
    .UPDATE_CYCLES(UC), .STEP(ST), .MAX_ANGLE(MAXA), .RESET_ANGLE(RSTA)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cif.slave),
    .angle1(angle1), .angle2(angle2), .angle3(angle3), .angle4(angle4),
    .nextangle(nextangle), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: m_phase counts cycles since INIT (-1 while in reset/INIT);
  // a tick is every UC-th cycle, and a change at a tick yields a strobe one cycle later.
  int m_cur [4];
  int m_tgt [4];
  bit m_next, m_busy, m_ready, m_pend, m_rq, m_tick, m_chg;
  int m_phase = -1;
  int m_d;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_cur[i] = RSTA; m_tgt[i] = RSTA; end
      m_next = 0; m_ready = 0; m_pend = 0; m_phase = -1;
    end else if (m_phase < 0) begin
      m_next = 1; m_ready = 1; m_phase = 0;
    end else begin
      m_rq = m_ready; m_next = m_pend; m_pend = 0; m_chg = 0;
      m_tick = (m_phase % UC) == UC - 1;
      if (m_tick)
        for (int i = 0; i < 4; i++) begin
          m_d = m_tgt[i] - m_cur[i];
          if (m_d > 0) begin m_cur[i] += (m_d < ST) ? m_d : ST; m_chg = 1; end
          else if (m_d < 0) begin m_cur[i] -= (-m_d < ST) ? -m_d : ST; m_chg = 1; end
        end
      m_pend = m_chg;
      if (cif.cmd_valid && m_rq)
        m_tgt[cif.cmd_ch] = (int'(cif.cmd_angle) > MAXA) ? MAXA : int'(cif.cmd_angle);
      m_phase++;
    end
    m_busy = 0;
    for (int i = 0; i < 4; i++) if (m_cur[i] != m_tgt[i]) m_busy = 1;
  end

  function automatic logic [34:0] dut_vec();
    return {angle1, angle2, angle3, angle4, nextangle, busy, cif.cmd_ready};
  endfunction

  function automatic logic [34:0] mdl_vec();
    return {8'(m_cur[0]), 8'(m_cur[1]), 8'(m_cur[2]), 8'(m_cur[3]), m_next, m_busy, m_ready};
  endfunction

  task automatic write_cmd(input logic [1:0] ch, input logic [7:0] ang);
    cif.cmd_valid = 1'b1; cif.cmd_ch = ch; cif.cmd_angle = ang;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
  endtask

  task automatic tick_align();
    while ((m_phase % UC) != UC - 1) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; cif.cmd_valid = 1'b0; cif.cmd_ch = '0; cif.cmd_angle = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); checks++;
    if (dut_vec() !== RST_VEC) begin errors++; $display("FAIL reset_hold: got %h exp %h", dut_vec(), RST_VEC); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); checks++;
    if (dut_vec() !== RST_VEC) begin errors++; $display("FAIL init_cycle: got %h exp %h", dut_vec(), RST_VEC); end
    @(posedge clk); #1;
    @(negedge clk); checks++;
    if (dut_vec() !== INIT_VEC || mdl_vec() !== INIT_VEC) begin errors++; $display("FAIL init_strobe: got %h exp %h", dut_vec(), INIT_VEC); end
    @(posedge clk); #1;
    @(negedge clk); checks++;
    if (dut_vec() !== IDLE_VEC) begin errors++; $display("FAIL init_strobe_end: got %h exp %h", dut_vec(), IDLE_VEC); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_slew();
    logic [7:0] seen [$];
    write_cmd(2'd0, 8'd96);
    for (int c = 0; c < 4 * UC + 4; c++) begin
      @(negedge clk); checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL basic_slew_cycle: got %h exp %h", dut_vec(), mdl_vec()); end
      if (nextangle) seen.push_back(angle1);
      @(posedge clk); #1;
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 8'd92 || seen[1] !== 8'd94 || seen[2] !== 8'd96) begin
      errors++; $display("FAIL basic_slew_seq: got %p exp 92,94,96", seen);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_slew_busy: got %b exp 0", busy); end
  endtask

  task automatic test_odd_down();
    logic [7:0] seen [$];
    int strobes = 0;
    write_cmd(2'd3, 8'd85);
    for (int c = 0; c < 4 * UC + 4; c++) begin
      @(negedge clk); checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL odd_down_cycle: got %h exp %h", dut_vec(), mdl_vec()); end
      if (nextangle) seen.push_back(angle4);
      @(posedge clk); #1;
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 8'd88 || seen[1] !== 8'd86 || seen[2] !== 8'd85) begin
      errors++; $display("FAIL odd_down_seq: got %p exp 88,86,85", seen);
    end
    write_cmd(2'd3, 8'd85);
    for (int c = 0; c < 2 * UC; c++) begin
      @(negedge clk);
      if (nextangle) strobes++;
      @(posedge clk); #1;
    end
    checks++;
    if (strobes != 0) begin errors++; $display("FAIL equal_write_strobe: got %0d strobes exp 0", strobes); end
  endtask

  task automatic test_clamp();
    int   upd = 0;
    int   amax = 0;
    bit   done = 0;
    logic [7:0] prev;
    write_cmd(2'd1, 8'd250);
    prev = angle2;
    for (int c = 0; c < 50 * UC + 10 && !done; c++) begin
      @(negedge clk); checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL clamp_cycle: got %h exp %h", dut_vec(), mdl_vec()); end
      if (angle2 != prev) upd++;
      if (int'(angle2) > amax) amax = int'(angle2);
      prev = angle2;
      if (angle2 == 8'd180) done = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (!done || upd != 45) begin errors++; $display("FAIL clamp_reach: got reached=%0d ticks=%0d exp reached=1 ticks=45", done, upd); end
    for (int c = 0; c < 2 * UC; c++) begin
      @(negedge clk);
      if (int'(angle2) > amax) amax = int'(angle2);
      @(posedge clk); #1;
    end
    checks++;
    if (amax != 180 || angle2 !== 8'd180) begin errors++; $display("FAIL clamp_hold: got max=%0d now=%0d exp 180", amax, angle2); end
  endtask

  task automatic test_simultaneous();
    bit         hit = 0;
    logic [7:0] first = '0;
    tick_align();
    write_cmd(2'd2, 8'd100);
    @(negedge clk); checks++;
    if (angle3 !== 8'd90 || busy !== 1'b1) begin errors++; $display("FAIL tick_write_old_tgt: got angle3=%0d busy=%b exp 90 1", angle3, busy); end
    for (int c = 0; c < UC; c++) begin
      @(posedge clk); #1;
      @(negedge clk); checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL simul_cycle: got %h exp %h", dut_vec(), mdl_vec()); end
    end
    checks++;
    if (angle3 !== 8'd92) begin errors++; $display("FAIL tick_write_next: got %0d exp 92", angle3); end
    for (int c = 0; c < 3 * UC && !hit; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (angle3 == 8'd94) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reach_94: got %0d exp 94 within budget", angle3); end
    @(posedge clk); #1;
    write_cmd(2'd2, 8'd80);
    hit = 0;
    for (int c = 0; c < UC + 2; c++) begin
      @(negedge clk); checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL retarget_cycle: got %h exp %h", dut_vec(), mdl_vec()); end
      if (!hit && angle3 != 8'd94) begin hit = 1; first = angle3; end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit || first !== 8'd92) begin errors++; $display("FAIL retarget_reverse: got %0d exp 92", first); end
  endtask

  task automatic test_reset_midslew();
    bit hit = 0;
    int strobes = 0;
    write_cmd(2'd0, 8'd150);
    for (int c = 0; c < 30 * UC && !hit; c++) begin
      @(negedge clk);
      if (angle1 == 8'd120) hit = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!hit || nextangle !== 1'b0) begin errors++; $display("FAIL reach_120: got angle1=%0d next=%b exp 120 0", angle1, nextangle); end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); checks++;
    if (dut_vec() !== RST_VEC) begin errors++; $display("FAIL reset_midslew: got %h exp %h", dut_vec(), RST_VEC); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL reinit_cycle: got %h exp %h", dut_vec(), mdl_vec()); end
      if (nextangle) strobes++;
      @(posedge clk); #1;
    end
    checks++;
    if (strobes != 1) begin errors++; $display("FAIL reinit_strobe: got %0d strobes exp 1", strobes); end
  endtask

  task automatic test_random();
    bit prev = 0;
    int consec = 0;
    bit idle = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(2) == 0) begin
        cif.cmd_valid = 1'b1;
        cif.cmd_ch    = 2'($urandom_range(3));
        cif.cmd_angle = 8'($urandom_range(255));
      end else begin
        cif.cmd_valid = 1'b0;
      end
      @(negedge clk); checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL random_cycle: got %h exp %h", dut_vec(), mdl_vec()); end
      if (nextangle && prev) consec++;
      prev = nextangle;
      @(posedge clk); #1;
    end
    cif.cmd_valid = 1'b0;
    checks++;
    if (consec != 0) begin errors++; $display("FAIL strobe_back_to_back: got %0d exp 0", consec); end
    for (int c = 0; c < 1200 && !idle; c++) begin
      @(negedge clk); checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL settle_cycle: got %h exp %h", dut_vec(), mdl_vec()); end
      if (!busy && !m_busy) idle = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (!idle || {angle1, angle2, angle3, angle4} !== {8'(m_tgt[0]), 8'(m_tgt[1]), 8'(m_tgt[2]), 8'(m_tgt[3])}) begin
      errors++; $display("FAIL settle_targets: got %0d %0d %0d %0d exp %0d %0d %0d %0d",
        angle1, angle2, angle3, angle4, m_tgt[0], m_tgt[1], m_tgt[2], m_tgt[3]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_slew();
    test_odd_down();
    test_clamp();
    test_simultaneous();
    test_reset_midslew();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete within time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/servo_angle_sequencer.md
# servo_angle_sequencer

Upstream command stage for the four-channel PWM servo controller. It accepts per-channel target angles over a valid/ready write port and slews each channel's output angle toward its target by a bounded step once per update period. After each update it emits a single-cycle `nextangle` strobe, so the PWM stage reloads all four angles in one transaction. Outputs connect directly to the controller's `angle1..angle4` and `nextangle` inputs.

## Interface
- `UPDATE_CYCLES`, default 1_000_000: clocks per update period (20 ms at 50 MHz). Must be ≥ 4.
- `STEP`, default 2: maximum change per channel per update, in degrees. Range 1..180.
- `MAX_ANGLE`, default 180: upper clamp for targets.
- `RESET_ANGLE`, default 90: reset value of targets and outputs. Must be ≤ `MAX_ANGLE`.

Ports:
- `clk`  in  1  system clock, 50 MHz, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  target write request.
- `cmd_ready`  out  1  write accept.
- `cmd_ch`  in  2  channel select: 0→angle1 … 3→angle4.
- `cmd_angle`  in  8  target angle, in degrees.
- `angle1`..`angle4`  out  8 each  current commanded angles.
- `nextangle`  out  1  one-cycle load strobe to the PWM stage.
- `busy`  out  1  high while any current angle differs from its target.

## Operation
- Reset values:
  - targets and `angle1..4` = `RESET_ANGLE`.
  - `nextangle` = 0, `busy` = 0, `cmd_ready` = 0.
  - period counter = 0, state = INIT.
- FSM states: INIT, WAIT, STROBE.
  - INIT: lasts exactly one cycle after `rst` falls. Asserts `nextangle` to load the reset angles downstream, then goes to WAIT.
  - WAIT: the free-running period counter counts 0..`UPDATE_CYCLES`-1 and wraps. On the cycle the counter equals `UPDATE_CYCLES`-1 (a "tick"), every channel updates:
    - if `cur < tgt`: `cur += min(STEP, tgt-cur)`.
    - if `cur > tgt`: `cur -= min(STEP, cur-tgt)`.
    - otherwise `cur` is unchanged.
    - If any channel changed, go to STROBE; otherwise stay in WAIT with no strobe.
  - STROBE: `nextangle` = 1 for exactly this cycle, then return to WAIT. The counter keeps running through STROBE.
- Command port:
  - `cmd_ready` = 1 in WAIT and STROBE, 0 in reset and INIT.
  - A write is accepted when `cmd_valid && cmd_ready`. The target register is written on that edge with `min(cmd_angle, MAX_ANGLE)`.
  - There is no backpressure beyond INIT; one write is accepted per cycle.
- Arithmetic: differences use 9-bit unsigned compare/subtract. Angles never exceed `MAX_ANGLE` and never underflow below 0; the step is clamped so a channel lands exactly on its target with no overshoot.
- `busy` is registered and equals the OR over channels of (`cur != tgt`), computed from the next-state values.

## Timing
- `angle1..4` change only on a tick edge. `nextangle` rises on the following edge, so angles are stable for at least one full cycle before and during the strobe.
- Write coinciding with a tick: that tick uses the old target. The new target takes effect at the next tick.
- A write whose target equals the current angle causes no strobe.
- Rewriting the target mid-slew redirects the channel at the next tick; direction may reverse.
- Update latency: a write accepted at cycle t moves the output at the first tick after t, and `nextangle` asserts one cycle later. Worst case is `UPDATE_CYCLES`+1 cycles.
- Full traverse from 0 to 180 takes `ceil(180/STEP)` ticks.
- `rst` asserted at any time, including mid-slew or during STROBE, forces the reset values on the next edge. Any strobe in progress is dropped, and INIT re-issues a strobe after release.
- `nextangle` is never high for two consecutive cycles. Strobes are separated by at least `UPDATE_CYCLES`-1 cycles, except for the INIT strobe.

## Test plan
Use parameters `UPDATE_CYCLES`=8, `STEP`=2 for all cases.
- **Reset/INIT:** hold `rst` 3 cycles, then release. Expect one `nextangle` pulse on the first cycle after release, all angles = 90, `cmd_ready` rising one cycle after release, `busy` = 0.
- **Basic slew:** write ch0 = 96. Expect `angle1` to step 92, 94, 96 on three consecutive ticks, each followed one cycle later by a one-cycle `nextangle`. `busy` falls with the final update, and no further strobes occur.
- **Odd remainder, downward:** write ch3 = 85. Expect `angle4` to step 88, 86, 85 with no overshoot past 85.
- **Clamp:** write ch1 = 250. Expect target 180, and `angle2` reaches 180 after 45 ticks and never exceeds it.
- **Simultaneous events:** write ch2 = 100 on a tick cycle. Expect `angle3` unchanged at that tick and 92 at the next tick. In a separate step, retarget ch2 from 100 to 80 while `angle3` = 94, and expect 92 on the next tick.
- **Reset mid-slew:** assert `rst` during STROBE while `angle1` = 120. Expect the strobe dropped and all outputs back to 90, followed by a single INIT strobe after release.
